// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Sequences a single-port data RAM and shares it between the CPU path
// (MAR/MDR) and the image DMA port. One access at a time; every output is
// registered. Read data returns RD_LAT cycles after the ram_en sampling edge
// and is handed back with a one-cycle acknowledge.
//
// Build option:
//   RAM_ARB_CPU_PRIORITY_EN  defined   -> CPU always wins a tie (fixed priority)
//                            undefined -> round-robin on ties (default)

module ram_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    // CPU requester
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    // Image DMA requester
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,

    // RAM side
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    // Status
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Owner encoding carried on gnt_id / last_gnt.
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    // RD_LAT is limited to 1..4, so the remaining-wait counter fits in 2 bits.
    localparam int               LAT_W    = 2;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    state_t state;
    state_t next_state;

    logic              last_gnt;
    logic [LAT_W-1:0]  lat_cnt;

    logic              req_any;
    logic              win_dma;

    logic              ram_en_nxt;
    logic              ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_nxt;
    logic              gnt_id_nxt;
    logic              last_gnt_nxt;
    logic [LAT_W-1:0]  lat_cnt_nxt;
    logic              cpu_ack_nxt;
    logic              dma_ack_nxt;
    logic [DATA_W-1:0] cpu_rdata_nxt;
    logic [DATA_W-1:0] dma_rdata_nxt;
    logic              busy_nxt;

    assign req_any = cpu_req | dma_req;

    // Pick the winner among the current requesters (only consulted in IDLE).
    always_comb begin
        win_dma = OWNER_CPU;
        if (cpu_req && dma_req) begin
`ifdef RAM_ARB_CPU_PRIORITY_EN
            // Fixed priority: the CPU always wins a tie; last_gnt is ignored.
            win_dma = OWNER_CPU;
`else
            // Round-robin: the port that did not win last time goes now.
            win_dma = ~last_gnt;
`endif
        end else begin
            win_dma = dma_req;
        end
    end

    // State register; reset aborts any access in flight.
    // NOTE: sequential state is written with non-blocking (<=) assignments so
    // every flop samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: a default on every combinationally-assigned signal keeps
        // paths that skip an assignment from inferring a latch.
        next_state = state;
        unique case (state)
            ST_IDLE:   next_state = req_any ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: next_state = ram_we ? ST_DONE : ST_WAIT;
            ST_WAIT:   next_state = (lat_cnt == '0) ? ST_DONE : ST_WAIT;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Output decode: next values of every registered output and side counter.
    always_comb begin
        ram_en_nxt    = 1'b0;
        ram_we_nxt    = ram_we;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;
        gnt_id_nxt    = gnt_id;
        last_gnt_nxt  = last_gnt;
        lat_cnt_nxt   = lat_cnt;
        cpu_ack_nxt   = 1'b0;
        dma_ack_nxt   = 1'b0;
        cpu_rdata_nxt = cpu_rdata;
        dma_rdata_nxt = dma_rdata;

        unique case (state)
            ST_IDLE: begin
                if (req_any) begin
                    // Requester inputs are sampled only here, at grant.
                    ram_en_nxt   = 1'b1;
                    gnt_id_nxt   = win_dma;
                    last_gnt_nxt = win_dma;
                    if (win_dma == OWNER_DMA) begin
                        ram_we_nxt    = dma_we;
                        ram_addr_nxt  = dma_addr;
                        ram_wdata_nxt = dma_wdata;
                    end else begin
                        ram_we_nxt    = cpu_we;
                        ram_addr_nxt  = cpu_addr;
                        ram_wdata_nxt = cpu_wdata;
                    end
                end
            end

            ST_ACCESS: begin
                // The strobe cycle ends here; ram_we must fall with ram_en.
                ram_we_nxt = 1'b0;
                if (ram_we) begin
                    cpu_ack_nxt = (gnt_id == OWNER_CPU);
                    dma_ack_nxt = (gnt_id == OWNER_DMA);
                end else begin
                    lat_cnt_nxt = LAT_INIT;
                end
            end

            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    // Read data is valid now; only the owner's register moves.
                    if (gnt_id == OWNER_DMA) begin
                        dma_rdata_nxt = ram_rdata;
                        dma_ack_nxt   = 1'b1;
                    end else begin
                        cpu_rdata_nxt = ram_rdata;
                        cpu_ack_nxt   = 1'b1;
                    end
                end else begin
                    lat_cnt_nxt = lat_cnt - 1'b1;
                end
            end

            ST_DONE: begin
                // Ack is already high this cycle; nothing else changes.
            end

            default: begin
            end
        endcase
    end

    assign busy_nxt = (next_state != ST_IDLE);

    // Output registers; last_gnt resets to DMA so the CPU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            gnt_id    <= OWNER_CPU;
            last_gnt  <= OWNER_DMA;
            lat_cnt   <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            ram_en    <= ram_en_nxt;
            ram_we    <= ram_we_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
            gnt_id    <= gnt_id_nxt;
            last_gnt  <= last_gnt_nxt;
            lat_cnt   <= lat_cnt_nxt;
            cpu_ack   <= cpu_ack_nxt;
            dma_ack   <= dma_ack_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            dma_rdata <= dma_rdata_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
// Directed bench for ram_access_arbiter. Two instances share clk/rst:
// dut (RD_LAT = 1) and dut_l3 (RD_LAT = 3), each with its own RAM model.
// Inputs change and outputs are sampled on the falling edge.

module tb_ram_access_arbiter;

    logic clk;
    logic rst;

    int total;
    int bad;

    // ---------------- instance with RD_LAT = 1 ----------------
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0]  cpu_addr, dma_addr;
    logic [15:0] cpu_wdata, dma_wdata;
    logic        cpu_ack, dma_ack;
    logic [15:0] cpu_rdata, dma_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        busy, gnt_id;

    ram_access_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    // RAM model, latency 1; returns filler when not reading.
    logic [15:0] mem_a [0:255];
    logic [15:0] rd_a;
    always @(posedge clk) begin
        if (ram_en && ram_we) mem_a[ram_addr] <= ram_wdata;
        rd_a <= (ram_en && !ram_we) ? mem_a[ram_addr] : 16'hDEAD;
    end
    assign ram_rdata = rd_a;

    // ---------------- instance with RD_LAT = 3 ----------------
    logic        b_cpu_req, b_cpu_we, b_dma_req, b_dma_we;
    logic [7:0]  b_cpu_addr, b_dma_addr;
    logic [15:0] b_cpu_wdata, b_dma_wdata;
    logic        b_cpu_ack, b_dma_ack;
    logic [15:0] b_cpu_rdata, b_dma_rdata;
    logic        b_ram_en, b_ram_we;
    logic [7:0]  b_ram_addr;
    logic [15:0] b_ram_wdata, b_ram_rdata;
    logic        b_busy, b_gnt_id;

    ram_access_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
        .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy), .gnt_id(b_gnt_id)
    );

    // RAM model, latency 3: three-stage read pipeline.
    logic [15:0] mem_b [0:255];
    logic [15:0] pb0, pb1, pb2;
    always @(posedge clk) begin
        if (b_ram_en && b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
        pb0 <= (b_ram_en && !b_ram_we) ? mem_b[b_ram_addr] : 16'hDEAD;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign b_ram_rdata = pb2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the sequence is fixed-length, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, dma_ack, cpu_rdata, dma_rdata, busy, gnt_id} !== 62'd0) begin
            bad++;
            $display("FAIL reset_outputs_a: got en=%b we=%b addr=%h wd=%h cack=%b dack=%b crd=%h drd=%h busy=%b gnt=%b exp all 0",
                     ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, dma_ack, cpu_rdata, dma_rdata, busy, gnt_id);
        end
        total++;
        if ({b_ram_en, b_ram_we, b_ram_addr, b_ram_wdata, b_cpu_ack, b_dma_ack, b_cpu_rdata, b_dma_rdata, b_busy, b_gnt_id} !== 62'd0) begin
            bad++;
            $display("FAIL reset_outputs_b: got nonzero output exp all 0");
        end
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || ram_en !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b en=%b exp 0 0", busy, ram_en);
        end
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 16'hABCD;
        tick(); // k+1
        total++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h10 || ram_wdata !== 16'hABCD || gnt_id !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL cpu_write_access: got en=%b we=%b addr=%h wd=%h gnt=%b busy=%b exp 1 1 10 abcd 0 1",
                     ram_en, ram_we, ram_addr, ram_wdata, gnt_id, busy);
        end
        total++;
        if (cpu_ack !== 1'b0) begin
            bad++;
            $display("FAIL cpu_write_early_ack: got %b exp 0", cpu_ack);
        end
        tick(); // k+2
        total++;
        if (cpu_ack !== 1'b1 || dma_ack !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0) begin
            bad++;
            $display("FAIL cpu_write_ack: got cack=%b dack=%b en=%b we=%b exp 1 0 0 0", cpu_ack, dma_ack, ram_en, ram_we);
        end
        cpu_req = 1'b0;
        tick(); // k+3
        total++;
        if (cpu_ack !== 1'b0 || busy !== 1'b0 || dma_ack !== 1'b0) begin
            bad++;
            $display("FAIL cpu_write_after: got cack=%b busy=%b dack=%b exp 0 0 0", cpu_ack, busy, dma_ack);
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = 16'h0000;
        tick(); // k+1
        total++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h10) begin
            bad++;
            $display("FAIL cpu_read_access: got en=%b we=%b addr=%h exp 1 0 10", ram_en, ram_we, ram_addr);
        end
        tick(); // k+2
        total++;
        if (cpu_ack !== 1'b0 || ram_en !== 1'b0 || ram_addr !== 8'h10) begin
            bad++;
            $display("FAIL cpu_read_wait: got ack=%b en=%b addr=%h exp 0 0 10", cpu_ack, ram_en, ram_addr);
        end
        tick(); // k+3
        total++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hABCD || dma_ack !== 1'b0) begin
            bad++;
            $display("FAIL cpu_read_ack: got ack=%b rdata=%h dack=%b exp 1 abcd 0", cpu_ack, cpu_rdata, dma_ack);
        end
        cpu_req = 1'b0;
        tick();
        tick();
        total++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 16'hABCD) begin
            bad++;
            $display("FAIL cpu_read_hold: got ack=%b rdata=%h exp 0 abcd", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_dma_write_top_addr();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'hFF; dma_wdata = 16'hFFFF;
        tick(); // k+1
        total++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'hFF || ram_wdata !== 16'hFFFF || gnt_id !== 1'b1) begin
            bad++;
            $display("FAIL dma_write_access: got en=%b we=%b addr=%h wd=%h gnt=%b exp 1 1 ff ffff 1",
                     ram_en, ram_we, ram_addr, ram_wdata, gnt_id);
        end
        tick(); // k+2
        total++;
        if (dma_ack !== 1'b1 || cpu_ack !== 1'b0 || cpu_rdata !== 16'hABCD || dma_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL dma_write_ack: got dack=%b cack=%b crd=%h drd=%h exp 1 0 abcd 0000",
                     dma_ack, cpu_ack, cpu_rdata, dma_rdata);
        end
        dma_req = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_gnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'h0C0C;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h80; dma_wdata = 16'hD0D0;
        for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_CPU_PRIORITY_EN
            exp_gnt = 1'b0;
`else
            exp_gnt = i[0];
`endif
            tick(); // ACCESS
            total++;
            if (ram_en !== 1'b1 || gnt_id !== exp_gnt || ram_addr !== (exp_gnt ? 8'h80 : 8'h40)) begin
                bad++;
                $display("FAIL arb_grant_%0d: got en=%b gnt=%b addr=%h exp 1 %b %h",
                         i, ram_en, gnt_id, ram_addr, exp_gnt, exp_gnt ? 8'h80 : 8'h40);
            end
            tick(); // DONE
            total++;
            if (cpu_ack !== ~exp_gnt || dma_ack !== exp_gnt) begin
                bad++;
                $display("FAIL arb_ack_%0d: got cack=%b dack=%b exp %b %b", i, cpu_ack, dma_ack, ~exp_gnt, exp_gnt);
            end
            if (i == 3) begin
                cpu_req = 1'b0;
                dma_req = 1'b0;
            end
            tick(); // IDLE
            total++;
            if (busy !== 1'b0 || ram_en !== 1'b0) begin
                bad++;
                $display("FAIL arb_idle_%0d: got busy=%b en=%b exp 0 0", i, busy, ram_en);
            end
        end
    endtask

    task automatic test_dma_read_lat3();
        int en_cnt;
        b_dma_req = 1'b1; b_dma_we = 1'b1; b_dma_addr = 8'h20; b_dma_wdata = 16'h5A5A;
        tick();
        tick();
        total++;
        if (b_dma_ack !== 1'b1) begin
            bad++;
            $display("FAIL l3_write_ack: got %b exp 1", b_dma_ack);
        end
        b_dma_req = 1'b0;
        tick();
        b_dma_req = 1'b1; b_dma_we = 1'b0; b_dma_addr = 8'h20; b_dma_wdata = 16'h0000;
        en_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (b_ram_en === 1'b1) en_cnt++;
            if (c < 5) begin
                total++;
                if (b_dma_ack !== 1'b0) begin
                    bad++;
                    $display("FAIL l3_early_ack_c%0d: got %b exp 0", c, b_dma_ack);
                end
            end
        end
        total++;
        if (b_dma_ack !== 1'b1 || b_dma_rdata !== 16'h5A5A || b_gnt_id !== 1'b1 || b_cpu_ack !== 1'b0) begin
            bad++;
            $display("FAIL l3_read_ack: got dack=%b rd=%h gnt=%b cack=%b exp 1 5a5a 1 0",
                     b_dma_ack, b_dma_rdata, b_gnt_id, b_cpu_ack);
        end
        total++;
        if (en_cnt !== 1) begin
            bad++;
            $display("FAIL l3_en_cycles: got %0d exp 1", en_cnt);
        end
        b_dma_req = 1'b0;
        tick();
        total++;
        if (b_dma_ack !== 1'b0 || b_dma_rdata !== 16'h5A5A) begin
            bad++;
            $display("FAIL l3_read_hold: got ack=%b rd=%h exp 0 5a5a", b_dma_ack, b_dma_rdata);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic saw_ack;
        b_dma_req = 1'b1; b_dma_we = 1'b0; b_dma_addr = 8'h20;
        tick(); // ACCESS
        tick(); // WAIT
        total++;
        if (b_busy !== 1'b1 || b_ram_en !== 1'b0) begin
            bad++;
            $display("FAIL midrst_in_wait: got busy=%b en=%b exp 1 0", b_busy, b_ram_en);
        end
        rst = 1'b1;
        b_dma_req = 1'b0;
        #1;
        total++;
        if ({b_ram_en, b_ram_we, b_ram_addr, b_ram_wdata, b_cpu_ack, b_dma_ack, b_cpu_rdata, b_dma_rdata, b_busy, b_gnt_id} !== 62'd0) begin
            bad++;
            $display("FAIL midrst_outputs: got en=%b addr=%h drd=%h busy=%b gnt=%b exp all 0",
                     b_ram_en, b_ram_addr, b_dma_rdata, b_busy, b_gnt_id);
        end
        tick();
        rst = 1'b0;
        saw_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (b_dma_ack !== 1'b0 || b_busy !== 1'b0) saw_ack = 1'b1;
        end
        total++;
        if (saw_ack !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_ack: got activity=%b exp 0", saw_ack);
        end
        // Re-issued read completes normally.
        b_dma_req = 1'b1;
        for (int c = 1; c <= 5; c++) tick();
        total++;
        if (b_dma_ack !== 1'b1 || b_dma_rdata !== 16'h5A5A) begin
            bad++;
            $display("FAIL midrst_reissue: got ack=%b rd=%h exp 1 5a5a", b_dma_ack, b_dma_rdata);
        end
        b_dma_req = 1'b0;
        tick();
    endtask

    task automatic test_req_drop();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 16'h1234;
        tick(); // ACCESS
        total++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h33) begin
            bad++;
            $display("FAIL drop_access: got en=%b we=%b addr=%h exp 1 1 33", ram_en, ram_we, ram_addr);
        end
        cpu_req = 1'b0;
        cpu_wdata = 16'hFFFF;
        tick(); // DONE
        total++;
        if (cpu_ack !== 1'b1) begin
            bad++;
            $display("FAIL drop_ack: got %b exp 1", cpu_ack);
        end
        tick(); // IDLE
        tick();
        total++;
        if (cpu_ack !== 1'b0 || busy !== 1'b0 || ram_en !== 1'b0) begin
            bad++;
            $display("FAIL drop_no_regrant: got ack=%b busy=%b en=%b exp 0 0 0", cpu_ack, busy, ram_en);
        end
        // Read back proves the write reached the RAM with the granted data.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33;
        tick();
        tick();
        tick();
        total++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h1234) begin
            bad++;
            $display("FAIL drop_readback: got ack=%b rd=%h exp 1 1234", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_dma_req = 1'b0; b_dma_we = 1'b0; b_dma_addr = '0; b_dma_wdata = '0;
        tick();

        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_dma_write_top_addr();
        test_round_robin();
        test_dma_read_lat3();
        test_reset_mid_wait();
        test_req_drop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Sequences the single-port data RAM (8-bit address, 16-bit word) and shares it between two requesters: the CPU path (CU driving MAR/MDR) and an image DMA port that streams pixel data in or out.
- Serialises accesses, generates the RAM enable, write and address/data strobes, and returns read data with a one-cycle acknowledge.
- Sits between the RAM and the MAR/MDR/DMA logic at the top of SYSTEM.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM word width.
- RD_LAT, 1, RAM read latency in cycles, from the ram_en sampling edge to ram_rdata valid. Legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  CPU read data, valid when cpu_ack is high, then held.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same directions, widths and meanings for the DMA port.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write strobe; high only together with ram_en.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  high in every state except IDLE.
- gnt_id  out  1  owner of the current or most recent access: 0 = CPU, 1 = DMA.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, last_gnt = 1 (so the CPU wins the first tie).
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req is high at an edge, select the winner and latch its we, addr and wdata into ram_we/ram_addr/ram_wdata.
  - Assert ram_en, set gnt_id, then go to ACCESS.
- Arbitration (round-robin):
  - Only one requester: it wins.
  - Both requesting: the port not equal to last_gnt wins.
  - last_gnt updates to the winner on grant.
- ACCESS:
  - ram_en is high for exactly this one cycle; ram_addr and ram_wdata are held.
  - Write: go to DONE.
  - Read: go to WAIT with lat_cnt = RD_LAT-1.
- WAIT:
  - ram_en = 0, ram_addr held.
  - While lat_cnt != 0, decrement it.
  - When lat_cnt == 0, capture ram_rdata into the owner's rdata register and go to DONE.
- DONE:
  - Owner's ack is high for one cycle; ram_we returns to 0; go to IDLE.
- Latency, with k = the cycle in which req is first seen in IDLE:
  - Write: ram_en high in k+1, ack high in k+2.
  - Read: ack high in k+2+RD_LAT.
  - Minimum spacing between back-to-back grants is 3 cycles for writes.
- A request still high in the cycle after its ack is treated as a new request.
- The non-owner's rdata holds its previous value. The non-owner's ack stays 0.
- A req dropped before its ack is a protocol violation. The access still completes and the ack is still pulsed.
- Changes to a loser's inputs while it waits are ignored; its inputs are sampled only at grant.
- Reset mid-access:
  - FSM returns to IDLE immediately and all strobes drop.
  - No ack is issued; the requester must re-request.
  - RAM contents for an interrupted write are undefined.
- The address space wraps naturally at 2^ADDR_W; there is no range checking.

Optional Feature:
- Macro: RAM_ARB_CPU_PRIORITY_EN.
- Defined: fixed priority. cpu_req always wins a tie in IDLE; last_gnt is still tracked but not used. The DMA can be starved by continuous CPU requests.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset, then CPU write addr 0x10 data 0xABCD: ram_en and ram_we high in k+1 with ram_addr 0x10 and ram_wdata 0xABCD; cpu_ack high in k+2; dma_ack stays 0.
- CPU read addr 0x10 with RD_LAT = 1 and the RAM model returning 0xABCD: cpu_ack high in k+3, cpu_rdata = 0xABCD and held afterwards.
- Both ports request writes in the same cycle after reset: CPU granted first (gnt_id = 0), DMA next (gnt_id = 1). With both held high continuously, grants alternate 0,1,0,1 across 4 accesses. With RAM_ARB_CPU_PRIORITY_EN defined, the CPU wins all 4.
- DMA read with RD_LAT = 3: dma_ack high in k+5, and ram_en is high for exactly one cycle.
- Assert rst in the WAIT cycle of a DMA read: all outputs 0 within that cycle, no dma_ack. After reset release, a re-issued request completes normally.
- CPU req dropped during ACCESS of a write: the write is still performed and cpu_ack still pulses once; the next IDLE grants nothing if no req is high.
